// File: rtl/key_debounce_n.sv
// key_debounce_n: per-key 2-flop synchroniser, debounce FSM and press/release pulses.
// Optional long-press pulse per key when KEY_LONG_PRESS_EN is defined.
module key_debounce_n #(
    parameter int   CLK_FRE       = 50_000_000,
    parameter int   DEBOUNCE_MS   = 20,
    parameter int   LONG_PRESS_MS = 1000,
    parameter int   CNT_WIDTH     = 28,
    parameter int   KEY_NUM       = 4,
    parameter logic KEY_ACT_LOW   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [KEY_NUM-1:0] keys_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int DB_CYC = CLK_FRE / 1000 * DEBOUNCE_MS;
    localparam int LP_CYC = CLK_FRE / 1000 * LONG_PRESS_MS;
    localparam logic [CNT_WIDTH-1:0] DB_MAX  = CNT_WIDTH'(DB_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    if (DB_CYC < 2) begin : g_chk_db
        $error("key_debounce_n: DB_CYC must be at least 2");
    end
    if (LP_CYC <= DB_CYC) begin : g_chk_lp
        $error("key_debounce_n: LP_CYC must exceed DB_CYC");
    end
    if (CNT_WIDTH < 31 && LP_CYC >= (1 << CNT_WIDTH)) begin : g_chk_w
        $error("key_debounce_n: CNT_WIDTH too narrow for LP_CYC");
    end

    typedef enum logic [1:0] {ST_UP, ST_P_FILT, ST_DOWN, ST_R_FILT} state_t;

    logic [KEY_NUM-1:0]   r_sync1, r_sync2, w_s;
    state_t               r_state     [KEY_NUM];
    state_t               w_state_nxt [KEY_NUM];
    logic [CNT_WIDTH-1:0] r_cnt       [KEY_NUM];
    logic [CNT_WIDTH-1:0] w_cnt_nxt   [KEY_NUM];
    logic [KEY_NUM-1:0]   r_press, r_release, w_press_nxt, w_release_nxt;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= {KEY_NUM{KEY_ACT_LOW}};
            r_sync2 <= {KEY_NUM{KEY_ACT_LOW}};
        end else begin
            r_sync1 <= keys_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = KEY_ACT_LOW ? ~r_sync2 : r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                r_state[i] <= ST_UP;
                r_cnt[i]   <= '0;
            end
            r_press   <= '0;
            r_release <= '0;
        end else begin
            for (int i = 0; i < KEY_NUM; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (!en) begin
                w_state_nxt[i] = ST_UP;
                w_cnt_nxt[i]   = '0;
            end else begin
                case (r_state[i])
                    ST_UP: if (w_s[i]) begin
                        w_state_nxt[i] = ST_P_FILT;
                        w_cnt_nxt[i]   = '0;
                    end
                    ST_P_FILT: if (!w_s[i]) begin
                        w_state_nxt[i] = ST_UP;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == DB_MAX) begin
                        w_state_nxt[i] = ST_DOWN;
                        w_cnt_nxt[i]   = '0;
                        w_press_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                    ST_DOWN: if (!w_s[i]) begin
                        w_state_nxt[i] = ST_R_FILT;
                        w_cnt_nxt[i]   = '0;
                    end
                    ST_R_FILT: if (w_s[i]) begin
                        w_state_nxt[i] = ST_DOWN;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == DB_MAX) begin
                        w_state_nxt[i]   = ST_UP;
                        w_cnt_nxt[i]     = '0;
                        w_release_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                    end
                    default: begin
                        w_state_nxt[i] = ST_UP;
                        w_cnt_nxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        key_state = '0;
        for (int i = 0; i < KEY_NUM; i++)
            key_state[i] = (r_state[i] == ST_DOWN) || (r_state[i] == ST_R_FILT);
    end

    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(LP_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] LP_PRE = CNT_WIDTH'(LP_CYC - 2);

    logic [CNT_WIDTH-1:0] r_hold [KEY_NUM];
    logic [KEY_NUM-1:0]   r_long;

    // Hold counter parks at LP_MAX so the long pulse fires once per stay in DOWN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_NUM; i++) r_hold[i] <= '0;
            r_long <= '0;
        end else begin
            for (int i = 0; i < KEY_NUM; i++) begin
                if (r_state[i] == ST_DOWN && w_state_nxt[i] == ST_DOWN) begin
                    if (r_hold[i] != LP_MAX) r_hold[i] <= r_hold[i] + CNT_ONE;
                    r_long[i] <= (r_hold[i] == LP_PRE);
                end else begin
                    r_hold[i] <= '0;
                    r_long[i] <= 1'b0;
                end
            end
        end
    end

    assign key_long = r_long;
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed bench for key_debounce_n: expected pulses are queued at stimulus time
// and matched against every cycle's press/release/long outputs.
module tb_key_debounce_n;

    localparam int KN     = 4;
    localparam int DB_CYC = 10;
    localparam int LP_CYC = 50;
    localparam int LAT    = DB_CYC + 2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b1;
    logic [KN-1:0] keys_in = '1;
    logic [KN-1:0] key_state, key_press, key_release, key_long;

    typedef struct {
        int t;
        int kind;
        int key;
    } ev_t;

    ev_t sb[$];
    int  cyc         = 0;
    int  vectors     = 0;
    int  miscompares = 0;

    key_debounce_n #(
        .CLK_FRE      (10_000),
        .DEBOUNCE_MS  (1),
        .LONG_PRESS_MS(5),
        .CNT_WIDTH    (8),
        .KEY_NUM      (KN),
        .KEY_ACT_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .keys_in    (keys_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input int kind, input int key, input int t);
        ev_t e;
        e.t    = t;
        e.kind = kind;
        e.key  = key;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_pulses();
        logic [KN-1:0] ep, er, el;
        ep = '0;
        er = '0;
        el = '0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].t == cyc) begin
                case (sb[j].kind)
                    K_PRESS: ep[sb[j].key] = 1'b1;
                    K_REL:   er[sb[j].key] = 1'b1;
                    default: el[sb[j].key] = 1'b1;
                endcase
                sb.delete(j);
            end
        end
        chk("key_press",   key_press,   ep);
        chk("key_release", key_release, er);
        chk("key_long",    key_long,    el);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_pulses();
        end
    endtask

    initial begin
        int tp;
        // reset state, asserted before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_state",   key_state,   4'b0000);
        chk("rst_press",   key_press,   4'b0000);
        chk("rst_release", key_release, 4'b0000);
        chk("rst_long",    key_long,    4'b0000);
        step(2);
        rst = 1'b0;
        step(3);

        // 1: clean press on key 0
        keys_in[0] = 1'b0;
        expect_ev(K_PRESS, 0, cyc + 1 + LAT);
        step(LAT);
        chk("t1_before", key_state, 4'b0000);
        step(1);
        chk("t1_state", key_state, 4'b0001);
        step(2);

        // 2: key 1 bounces every 3 cycles, then settles pressed
        repeat (20) begin
            keys_in[1] = ~keys_in[1];
            step(3);
        end
        chk("t2_bounce", key_state, 4'b0001);
        keys_in[1] = 1'b0;
        expect_ev(K_PRESS, 1, cyc + 1 + LAT);
        step(LAT + 3);
        chk("t2_state", key_state, 4'b0011);

        // 3: release key 0 cleanly; release key 1 with a one-cycle glitch
        keys_in[0] = 1'b1;
        expect_ev(K_REL, 0, cyc + 1 + LAT);
        step(LAT + 1);
        chk("t3_rel0", key_state, 4'b0010);
        keys_in[1] = 1'b1;
        step(5);
        keys_in[1] = 1'b0;
        step(1);
        keys_in[1] = 1'b1;
        expect_ev(K_REL, 1, cyc + 1 + LAT);
        step(LAT);
        chk("t3_glitch_hold", key_state, 4'b0010);
        step(2);
        chk("t3_rel1", key_state, 4'b0000);

        // 4: long hold on key 2
        keys_in[2] = 1'b0;
        tp = cyc + 1 + LAT;
        expect_ev(K_PRESS, 2, tp);
`ifdef KEY_LONG_PRESS_EN
        expect_ev(K_LONG, 2, tp + LP_CYC - 1);
`endif
        step(LAT + 1 + 100);
        chk("t4_held", key_state, 4'b0100);
        keys_in[2] = 1'b1;
        expect_ev(K_REL, 2, cyc + 1 + LAT);
        step(LAT + 3);

        // 5: async reset while key 3 is down
        keys_in[3] = 1'b0;
        expect_ev(K_PRESS, 3, cyc + 1 + LAT);
        step(LAT + 5);
        chk("t5_down", key_state, 4'b1000);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clr", key_state, 4'b0000);
        step(2);
        rst = 1'b0;
        expect_ev(K_PRESS, 3, cyc + 1 + LAT);
        step(LAT + 2);
        chk("t5_repress", key_state, 4'b1000);
        keys_in[3] = 1'b1;
        expect_ev(K_REL, 3, cyc + 1 + LAT);
        step(LAT + 3);

        // 6: all keys together, then en dropped mid-press and restored
        keys_in = 4'b0000;
        for (int k = 0; k < KN; k++) expect_ev(K_PRESS, k, cyc + 1 + LAT);
        step(LAT + 1);
        chk("t6_all", key_state, 4'b1111);
        step(4);
        en = 1'b0;
        step(1);
        chk("t6_en_off", key_state, 4'b0000);
        step(15);
        chk("t6_en_off_hold", key_state, 4'b0000);
        en = 1'b1;
        for (int k = 0; k < KN; k++) expect_ev(K_PRESS, k, cyc + 1 + DB_CYC);
        step(DB_CYC + 3);
        chk("t6_en_on", key_state, 4'b1111);
        keys_in = 4'b1111;
        for (int k = 0; k < KN; k++) expect_ev(K_REL, k, cyc + 1 + LAT);
        step(LAT + 3);
        chk("t6_final", key_state, 4'b0000);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
